// File: rtl/action_engine_pkg.sv
// Shared opcodes, sub-action field positions and container widths for the
// match-action stage action engine.
package action_engine_pkg;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_SUB     = 4'd2;
  localparam logic [3:0] OP_ADDI    = 4'd3;
  localparam logic [3:0] OP_SUBI    = 4'd4;
  localparam logic [3:0] OP_SET     = 4'd5;
  localparam logic [3:0] OP_COPY    = 4'd6;
  localparam logic [3:0] OP_DISCARD = 4'd15;

  localparam int OPC_MSB  = 24;
  localparam int OPC_W    = 4;
  localparam int SELA_LSB = 16;
  localparam int SELB_LSB = 11;
  localparam int SEL_W    = 5;
  localparam int IMM_W    = 16;

  localparam int W2B = 16;
  localparam int W4B = 32;
  localparam int W6B = 48;

  function automatic logic is_bad_lane_op(input logic [3:0] opc);
    return opc > OP_COPY;
  endfunction

  function automatic logic is_bad_meta_op(input logic [3:0] opc);
    return (opc != OP_NOP) && (opc != OP_DISCARD);
  endfunction

endpackage

// File: rtl/action_alu_lane.sv
// One container lane: operand index mux into S1 registers, ALU into S2 registers.
// Latency 2 (S1 on s1_load, S2 when stall_in is low).
// Backpressure: stall_in freezes S2; S1 only loads on s1_load.
module action_alu_lane
  import action_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 8,
  parameter int ACT_LEN    = 25
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s1_load,
  input  logic                            stall_in,
  input  logic [ACT_LEN-1:0]              act_in,
  input  logic [DATA_WIDTH-1:0]           own_in,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_in,
  output logic [DATA_WIDTH-1:0]           res_out
);

  logic [OPC_W-1:0]      opc_d, opc_q;
  logic [IMM_W-1:0]      imm_d, imm_q;
  logic [DATA_WIDTH-1:0] own_d, own_q, a_d, a_q, b_d, b_q, res_d, res_q;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [SEL_W-1:0]      sel_a, sel_b;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_a = act_in[SELA_LSB +: SEL_W];
    sel_b = act_in[SELB_LSB +: SEL_W];
    a_d   = '0;
    b_d   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(sel_a) == i) a_d = src_in[i*DATA_WIDTH +: DATA_WIDTH];
      if (int'(sel_b) == i) b_d = src_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
    opc_d = act_in[OPC_MSB -: OPC_W];
    imm_d = act_in[IMM_W-1:0];
    own_d = own_in;
  end

  assign imm_ext = DATA_WIDTH'(imm_q);

  always_comb begin
    res_d = own_q;
    case (opc_q)
      OP_ADD:  res_d = a_q + b_q;
      OP_SUB:  res_d = a_q - b_q;
      OP_ADDI: res_d = a_q + imm_ext;
      OP_SUBI: res_d = a_q - imm_ext;
      OP_SET:  res_d = imm_ext;
      OP_COPY: res_d = a_q;
      default: res_d = own_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q <= '0;
      imm_q <= '0;
      own_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      if (s1_load) begin
        opc_q <= opc_d;
        imm_q <= imm_d;
        own_q <= own_d;
        a_q   <= a_d;
        b_q   <= b_d;
      end
      if (!stall_in) res_q <= res_d;
    end
  end

  assign res_out = res_q;

endmodule

// File: rtl/action_engine_pipe.sv
// Action engine for one RMT stage: one sub-action per PHV container; ACTION_ENGINE_STATS_EN adds counters.
// Latency 2 cycles from accept to phv_valid_out; 1 PHV/cycle sustained.
// Backpressure: output holds while !phv_ready_in; phv_ready_out drops combinationally when both stages full.
module action_engine_pipe
  import action_engine_pkg::*;
#(
  parameter int STAGE            = 0,
  parameter int NUM_2B           = 8,
  parameter int NUM_4B           = 8,
  parameter int NUM_6B           = 8,
  parameter int META_LEN         = 356,
  parameter int ACT_LEN          = 25,
  parameter int META_DISCARD_BIT = 128,
  localparam int PHV_LEN = W6B*NUM_6B + W4B*NUM_4B + W2B*NUM_2B + META_LEN,
  localparam int ACT_NUM = NUM_2B + NUM_4B + NUM_6B + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PHV_LEN-1:0]         phv_in,
  input  logic                       phv_valid_in,
  input  logic [ACT_LEN*ACT_NUM-1:0] action_in,
  input  logic                       action_valid_in,
  output logic                       phv_ready_out,
  output logic [PHV_LEN-1:0]         phv_out,
  output logic                       phv_valid_out,
  input  logic                       phv_ready_in
`ifdef ACTION_ENGINE_STATS_EN
  ,
  output logic [31:0]                stat_pkt_cnt,
  output logic [31:0]                stat_bad_op_cnt
`endif
);

  localparam int B2 = META_LEN;
  localparam int B4 = B2 + NUM_2B*W2B;
  localparam int B6 = B4 + NUM_4B*W4B;

  logic s1_vld_d, s1_vld_q, s2_vld_d, s2_vld_q;
  logic s2_adv, s2_load, s2_stall, accept;
  logic [META_LEN-1:0] meta_d, meta_q, meta_out_d, meta_out_q;
  logic [OPC_W-1:0]    meta_opc_d, meta_opc_q;

  assign s2_adv        = !s2_vld_q || phv_ready_in;
  assign phv_ready_out = !s1_vld_q || s2_adv;
  assign accept        = phv_valid_in && action_valid_in && phv_ready_out;
  assign s2_load       = s2_adv && s1_vld_q;
  assign s2_stall      = !s2_load;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      s1_vld_d = 1'b0;
    end
    if (accept) s1_vld_d = 1'b1;
  end

  always_comb begin
    meta_d     = phv_in[META_LEN-1:0];
    meta_opc_d = action_in[OPC_MSB -: OPC_W];
    meta_out_d = meta_q;
    if (meta_opc_q == OP_DISCARD) meta_out_d[META_DISCARD_BIT] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      meta_q     <= '0;
      meta_opc_q <= '0;
      meta_out_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (accept) begin
        meta_q     <= meta_d;
        meta_opc_q <= meta_opc_d;
      end
      if (s2_load) meta_out_q <= meta_out_d;
    end
  end

  assign phv_valid_out          = s2_vld_q;
  assign phv_out[META_LEN-1:0]  = meta_out_q;

  // Operands always come from the input PHV of the same class, never from sibling results.
  for (genvar i = 0; i < NUM_2B; i++) begin : g_2b
    action_alu_lane #(.DATA_WIDTH(W2B), .NUM_SRC(NUM_2B), .ACT_LEN(ACT_LEN)) u_lane (
      .clk(clk), .rst_n(rst_n), .s1_load(accept), .stall_in(s2_stall),
      .act_in(action_in[(1+i)*ACT_LEN +: ACT_LEN]),
      .own_in(phv_in[B2 + i*W2B +: W2B]),
      .src_in(phv_in[B2 +: NUM_2B*W2B]),
      .res_out(phv_out[B2 + i*W2B +: W2B])
    );
  end

  for (genvar i = 0; i < NUM_4B; i++) begin : g_4b
    action_alu_lane #(.DATA_WIDTH(W4B), .NUM_SRC(NUM_4B), .ACT_LEN(ACT_LEN)) u_lane (
      .clk(clk), .rst_n(rst_n), .s1_load(accept), .stall_in(s2_stall),
      .act_in(action_in[(1+NUM_2B+i)*ACT_LEN +: ACT_LEN]),
      .own_in(phv_in[B4 + i*W4B +: W4B]),
      .src_in(phv_in[B4 +: NUM_4B*W4B]),
      .res_out(phv_out[B4 + i*W4B +: W4B])
    );
  end

  for (genvar i = 0; i < NUM_6B; i++) begin : g_6b
    action_alu_lane #(.DATA_WIDTH(W6B), .NUM_SRC(NUM_6B), .ACT_LEN(ACT_LEN)) u_lane (
      .clk(clk), .rst_n(rst_n), .s1_load(accept), .stall_in(s2_stall),
      .act_in(action_in[(1+NUM_2B+NUM_4B+i)*ACT_LEN +: ACT_LEN]),
      .own_in(phv_in[B6 + i*W6B +: W6B]),
      .src_in(phv_in[B6 +: NUM_6B*W6B]),
      .res_out(phv_out[B6 + i*W6B +: W6B])
    );
  end

`ifdef ACTION_ENGINE_STATS_EN
  logic [31:0] pkt_cnt_d, pkt_cnt_q, bad_cnt_d, bad_cnt_q;
  logic        bad_op;

  // One bad_op count per PHV, however many slots are illegal.
  always_comb begin
    bad_op = is_bad_meta_op(action_in[OPC_MSB -: OPC_W]);
    for (int s = 1; s < ACT_NUM; s++) begin
      if (is_bad_lane_op(action_in[s*ACT_LEN + OPC_MSB -: OPC_W])) bad_op = 1'b1;
    end
    pkt_cnt_d = pkt_cnt_q;
    bad_cnt_d = bad_cnt_q;
    if (accept && (pkt_cnt_q != '1))           pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (accept && bad_op && (bad_cnt_q != '1)) bad_cnt_d = bad_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      bad_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end

  assign stat_pkt_cnt    = pkt_cnt_q;
  assign stat_bad_op_cnt = bad_cnt_q;
`endif

endmodule

// File: tb/tb_action_engine_pipe.sv
// Scoreboard bench for action_engine_pipe: expected PHVs queued on accept, compared on output handshake.
module tb_action_engine_pipe;
  import action_engine_pkg::*;

  localparam int META_LEN = 356;
  localparam int ACT_LEN  = 25;
  localparam int ACT_NUM  = 25;
  localparam int B2       = META_LEN;
  localparam int B4       = B2 + 8*16;
  localparam int B6       = B4 + 8*32;
  localparam int PHV_LEN  = B6 + 8*48;
  localparam int ACT_W    = ACT_LEN*ACT_NUM;

  logic               clk, rst_n;
  logic [PHV_LEN-1:0] phv_in, phv_out;
  logic [ACT_W-1:0]   action_in;
  logic               phv_valid_in, action_valid_in, phv_ready_out, phv_valid_out, phv_ready_in;
`ifdef ACTION_ENGINE_STATS_EN
  logic [31:0]        stat_pkt_cnt, stat_bad_op_cnt;
`endif

  action_engine_pipe #(
    .STAGE(0), .NUM_2B(8), .NUM_4B(8), .NUM_6B(8),
    .META_LEN(META_LEN), .ACT_LEN(ACT_LEN), .META_DISCARD_BIT(128)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .phv_in(phv_in), .phv_valid_in(phv_valid_in),
    .action_in(action_in), .action_valid_in(action_valid_in),
    .phv_ready_out(phv_ready_out),
    .phv_out(phv_out), .phv_valid_out(phv_valid_out),
    .phv_ready_in(phv_ready_in)
`ifdef ACTION_ENGINE_STATS_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_bad_op_cnt(stat_bad_op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int acc_cnt = 0;
  logic [PHV_LEN-1:0] sb_q[$];
  logic [PHV_LEN-1:0] last_out, held_dat;
  logic               held_vld = 1'b0;

  task automatic check(input string tag, input logic [PHV_LEN-1:0] got, input logic [PHV_LEN-1:0] exp);
    int lo;
    logic [127:0] gw, ew;
    checks++;
    if (got !== exp) begin
      errors++;
      lo = 0;
      for (int b = PHV_LEN-1; b >= 0; b--) if (got[b] !== exp[b]) lo = b - (b % 128);
      gw = 128'(got >> lo);
      ew = 128'(exp >> lo);
      $display("FAIL %s: got %0h expected %0h (window from bit %0d)", tag, gw, ew, lo);
    end
  endtask

  function automatic logic [47:0] getc(input logic [PHV_LEN-1:0] p, input int base, input int w, input int idx);
    logic [47:0] v;
    v = '0;
    for (int b = 0; b < w; b++) v[b] = p[base + idx*w + b];
    return v;
  endfunction

  function automatic logic [PHV_LEN-1:0] setc(input logic [PHV_LEN-1:0] p, input int base, input int w,
                                             input int idx, input logic [47:0] v);
    for (int b = 0; b < w; b++) p[base + idx*w + b] = v[b];
    return p;
  endfunction

  function automatic logic [24:0] op_ab(input logic [3:0] op, input int sa, input int sb);
    return {op, 5'(sa), 5'(sb), 11'd0};
  endfunction

  function automatic logic [24:0] op_imm(input logic [3:0] op, input int sa, input logic [15:0] imm);
    return {op, 5'(sa), imm};
  endfunction

  // Reference behaviour: every operand read from the unmodified input PHV.
  function automatic logic [PHV_LEN-1:0] model(input logic [PHV_LEN-1:0] p, input logic [ACT_W-1:0] a);
    logic [PHV_LEN-1:0] r;
    logic [24:0] s;
    logic [47:0] m, va, vb, vi, vo, v;
    int w, base, slot;
    r = p;
    if (a[24:21] == 4'd15) r[128] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      w    = (c == 0) ? 16 : (c == 1) ? 32 : 48;
      base = (c == 0) ? B2 : (c == 1) ? B4 : B6;
      slot = 1 + 8*c;
      m    = (w == 48) ? 48'hFFFF_FFFF_FFFF : ((48'd1 << w) - 48'd1);
      for (int i = 0; i < 8; i++) begin
        s  = a[(slot+i)*ACT_LEN +: 25];
        va = (s[20:16] < 8) ? getc(p, base, w, int'(s[20:16])) : 48'd0;
        vb = (s[15:11] < 8) ? getc(p, base, w, int'(s[15:11])) : 48'd0;
        vi = {32'd0, s[15:0]};
        vo = getc(p, base, w, i);
        case (s[24:21])
          4'd1:    v = va + vb;
          4'd2:    v = va - vb;
          4'd3:    v = va + vi;
          4'd4:    v = va - vi;
          4'd5:    v = vi;
          4'd6:    v = va;
          default: v = vo;
        endcase
        r = setc(r, base, w, i, v & m);
      end
    end
    return r;
  endfunction

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] p;
    for (int b = 0; b < PHV_LEN; b++) p[b] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic logic [ACT_W-1:0] rand_act();
    logic [ACT_W-1:0] a;
    for (int s = 0; s < ACT_NUM; s++) begin
      if (s == 0) a[24:0] = op_ab($urandom_range(0, 1) ? 4'd15 : 4'd0, 0, 0);
      else a[s*ACT_LEN +: 25] = op_imm(4'($urandom_range(0, 8)), $urandom_range(0, 15), 16'($urandom));
    end
    return a;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("hold_valid", phv_valid_out, 1);
        check("hold_data", phv_out, held_dat);
      end
      held_vld = phv_valid_out && !phv_ready_in;
      held_dat = phv_out;
      if (phv_valid_out && phv_ready_in) begin
        out_cnt++;
        last_out = phv_out;
        if (sb_q.size() == 0) check("unexpected_out", 1, 0);
        else check("phv_out", phv_out, sb_q.pop_front());
      end
      if (phv_valid_in && action_valid_in && phv_ready_out) begin
        sb_q.push_back(model(phv_in, action_in));
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [PHV_LEN-1:0] p, input logic [ACT_W-1:0] a);
    int  n;
    logic acc;
    n = 0;
    phv_in = p; action_in = a; phv_valid_in = 1'b1; action_valid_in = 1'b1;
    do begin
      @(negedge clk); acc = phv_ready_out;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", 0, 1);
    phv_valid_in = 1'b0; action_valid_in = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_cnt < target && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_cnt < target) check("output_timeout", PHV_LEN'(out_cnt), PHV_LEN'(target));
  endtask

  initial begin
    logic [PHV_LEN-1:0] p;
    logic [ACT_W-1:0]   a;
    int base;
    rst_n = 1'b0; phv_valid_in = 1'b0; action_valid_in = 1'b0; phv_ready_in = 1'b1;
    phv_in = '0; action_in = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_valid_out", phv_valid_out, 0);
    check("rst_phv_out", phv_out, 0);
    check("rst_ready_out", phv_ready_out, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic, select and metadata cases in one PHV.
    p = rand_phv();
    p = setc(p, B4, 32, 0, 48'hFFFF_FFFF);
    p = setc(p, B4, 32, 1, 48'd2);
    p = setc(p, B4, 32, 2, 48'd1);
    p[128] = 1'b0;
    a = '0;
    a[0 +: 25]                  = op_ab(OP_DISCARD, 0, 0);
    a[1*ACT_LEN +: 25]          = op_ab(OP_COPY, 9, 0);
    a[(1+8+0)*ACT_LEN +: 25]    = op_ab(OP_ADD, 0, 1);
    a[(1+8+3)*ACT_LEN +: 25]    = op_imm(OP_SUBI, 2, 16'd3);
    a[(1+16+0)*ACT_LEN +: 25]   = op_imm(OP_SET, 0, 16'hBEEF);
    base = out_cnt;
    send(p, a);
    check("latency_edge1", phv_valid_out, 0);
    @(posedge clk); #1;
    check("latency_edge2", phv_valid_out, 1);
    wait_out(base + 1);
    check("add_wrap_4b", getc(last_out, B4, 32, 0), 48'h1);
    check("subi_wrap_4b", getc(last_out, B4, 32, 3), 48'hFFFF_FFFE);
    check("set_6b", getc(last_out, B6, 48, 0), 48'h0000_0000_BEEF);
    check("copy_oor_2b", getc(last_out, B2, 16, 0), 48'h0);
    check("nop_4b_lane", getc(last_out, B4, 32, 5), getc(p, B4, 32, 5));
    check("nop_6b_lane", getc(last_out, B6, 48, 7), getc(p, B6, 48, 7));
    check("discard_bit", last_out[128], 1);

    // Random back-to-back traffic.
    base = out_cnt;
    for (int k = 0; k < 20; k++) send(rand_phv(), rand_act());
    wait_out(base + 20);

    // Backpressure: ready_in low in cycles 3..6 of a 4-PHV stream.
    base = out_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) send(rand_phv(), rand_act());
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        phv_ready_in = 1'b0;
        for (int c = 3; c <= 6; c++) begin
          #1 check("bp_ready_out_full", phv_ready_out, 0);
          @(posedge clk); #1;
        end
        phv_ready_in = 1'b1;
      end
    join
    wait_out(base + 4);
    repeat (3) begin @(posedge clk); #1; end
    check("bp_out_count", PHV_LEN'(out_cnt - base), 4);
    check("bp_sb_empty", PHV_LEN'(sb_q.size()), 0);

    // Unpaired valids: PHV without action for three cycles.
    base = out_cnt;
    phv_in = rand_phv(); action_in = rand_act();
    phv_valid_in = 1'b1; action_valid_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("pair_ready_out", phv_ready_out, 1);
      check("pair_no_valid_out", phv_valid_out, 0);
      @(posedge clk); #1;
    end
    action_valid_in = 1'b1;
    @(posedge clk); #1;
    phv_valid_in = 1'b0; action_valid_in = 1'b0;
    @(posedge clk); #1;
    check("pair_valid_out", phv_valid_out, 1);
    repeat (4) begin @(posedge clk); #1; end
    check("pair_out_count", PHV_LEN'(out_cnt - base), 1);

    // Reset with a PHV in flight drops it.
    base = out_cnt;
    send(rand_phv(), rand_act());
    #2 rst_n = 1'b0;
    #1;
    check("midrst_phv_out", phv_out, 0);
    check("midrst_valid_out", phv_valid_out, 0);
    check("midrst_ready_out", phv_ready_out, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_idle", phv_valid_out, 0);
    end
    check("post_rst_no_out", PHV_LEN'(out_cnt - base), 0);

`ifdef ACTION_ENGINE_STATS_EN
    check("stat_pkt_rst", stat_pkt_cnt, 0);
    check("stat_bad_rst", stat_bad_op_cnt, 0);
    base = out_cnt;
    for (int k = 0; k < 5; k++) begin
      a = '0;
      if (k == 1) begin
        a[3*ACT_LEN +: 25]  = op_ab(4'd9, 0, 0);
        a[12*ACT_LEN +: 25] = op_ab(4'd9, 0, 0);
      end
      if (k == 2) a[0 +: 25] = op_ab(OP_DISCARD, 0, 0);
      send(rand_phv(), a);
    end
    wait_out(base + 5);
    check("stat_pkt_cnt", stat_pkt_cnt, 5);
    check("stat_bad_op_cnt", stat_bad_op_cnt, 1);
`endif

    repeat (2) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
